// File: rtl/act_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : act_sequencer
// Summary  : Walks a block of elements through the fixed-latency activation
//            datapath: one buffer read per cycle, matching write-back after
//            PIPE_LATENCY cycles, start/done handshake to the layer controller.
//            Optional build macro ACT_SEQ_STALL_EN adds a stall input.
// Revision : 1.0 - initial release
// ============================================================================
module act_sequencer #(
  parameter int ADDR_WIDTH   = 6,
  parameter int PIPE_LATENCY = 3
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH-1:0] length,
  input  logic [1:0]            func_sel,
`ifdef ACT_SEQ_STALL_EN
  input  logic                  stall,
`endif
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [1:0]            act_func,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] c_one = ADDR_WIDTH'(1);

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [ADDR_WIDTH-1:0]   r_base;
  logic [ADDR_WIDTH-1:0]   r_len;
  logic [1:0]              r_func;
  logic [ADDR_WIDTH-1:0]   r_issue_cnt;
  logic [ADDR_WIDTH-1:0]   r_wr_cnt;
  logic [ADDR_WIDTH-1:0]   r_rd_addr;
  logic                    r_rd_en;
  logic                    r_busy;
  logic                    r_done;
  logic [PIPE_LATENCY-1:0] r_pipe_vld;
  logic [ADDR_WIDTH-1:0]   r_pipe_addr [PIPE_LATENCY];

  logic [ADDR_WIDTH-1:0]   w_issue_cnt_nxt;
  logic [ADDR_WIDTH-1:0]   w_wr_cnt_nxt;
  logic [ADDR_WIDTH-1:0]   w_rd_addr_nxt;
  logic                    w_rd_en_nxt;
  logic                    w_done_nxt;
  logic                    w_busy_nxt;
  logic                    w_load;
  logic                    w_stall;
  logic                    w_rd_fire;
  logic                    w_wr_fire;
  logic                    w_last_rd;
  logic                    w_last_wr;

`ifdef ACT_SEQ_STALL_EN
  assign w_stall = stall & ((r_state == S_ISSUE) | (r_state == S_DRAIN));
`else
  assign w_stall = 1'b0;
`endif

  // A stall masks the strobes in the same cycle; everything else simply holds.
  assign w_rd_fire = r_rd_en & ~w_stall;
  assign w_wr_fire = r_pipe_vld[PIPE_LATENCY-1] & ~w_stall;
  assign w_last_rd = (r_issue_cnt == (r_len - c_one));
  assign w_last_wr = (r_wr_cnt == (r_len - c_one));

  always_comb begin
    w_state_nxt     = r_state;
    w_issue_cnt_nxt = r_issue_cnt;
    w_wr_cnt_nxt    = r_wr_cnt;
    w_rd_addr_nxt   = r_rd_addr;
    w_rd_en_nxt     = r_rd_en;
    w_done_nxt      = 1'b0;
    w_load          = 1'b0;

    if (w_wr_fire) begin
      w_wr_cnt_nxt = r_wr_cnt + c_one;
    end

    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_load          = 1'b1;
          w_issue_cnt_nxt = '0;
          w_wr_cnt_nxt    = '0;
          w_rd_addr_nxt   = base_addr;
          if (length == '0) begin
            w_state_nxt = S_DONE;
            w_done_nxt  = 1'b1;
          end else begin
            w_state_nxt = S_ISSUE;
            w_rd_en_nxt = 1'b1;
          end
        end
      end
      S_ISSUE: begin
        if (!w_stall) begin
          w_issue_cnt_nxt = r_issue_cnt + c_one;
          w_rd_addr_nxt   = r_base + w_issue_cnt_nxt;
          if (w_last_rd) begin
            w_state_nxt = S_DRAIN;
            w_rd_en_nxt = 1'b0;
          end
        end
      end
      S_DRAIN: begin
        if (w_wr_fire && w_last_wr) begin
          w_state_nxt = S_DONE;
          w_done_nxt  = 1'b1;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    w_busy_nxt = (w_state_nxt != S_IDLE);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_base      <= '0;
      r_len       <= '0;
      r_func      <= '0;
      r_issue_cnt <= '0;
      r_wr_cnt    <= '0;
      r_rd_addr   <= '0;
      r_rd_en     <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      if (w_load) begin
        r_base <= base_addr;
        r_len  <= length;
        r_func <= func_sel;
      end
      r_issue_cnt <= w_issue_cnt_nxt;
      r_wr_cnt    <= w_wr_cnt_nxt;
      r_rd_addr   <= w_rd_addr_nxt;
      r_rd_en     <= w_rd_en_nxt;
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
    end
  end

  // Delay line mirrors the datapath latency so the write lands with its result.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_pipe_vld <= '0;
      for (int i = 0; i < PIPE_LATENCY; i++) begin
        r_pipe_addr[i] <= '0;
      end
    end else if (!w_stall) begin
      r_pipe_vld[0]  <= w_rd_fire;
      r_pipe_addr[0] <= r_rd_addr;
      for (int i = 1; i < PIPE_LATENCY; i++) begin
        r_pipe_vld[i]  <= r_pipe_vld[i-1];
        r_pipe_addr[i] <= r_pipe_addr[i-1];
      end
    end
  end

  assign rd_en    = w_rd_fire;
  assign rd_addr  = r_rd_addr;
  assign wr_en    = w_wr_fire;
  assign wr_addr  = r_pipe_addr[PIPE_LATENCY-1];
  assign busy     = r_busy;
  assign done     = r_done;
  assign act_func = r_func;

endmodule
`default_nettype wire

// File: tb/tb_act_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_act_sequencer
// Summary  : Randomized self-checking bench for act_sequencer against a
//            cycle-schedule reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_act_sequencer;

  localparam int AW = 6;
  localparam int L  = 3;

  logic          clock;
  logic          reset_n;
  logic          start;
  logic          stall;
  logic [AW-1:0] base_addr;
  logic [AW-1:0] length;
  logic [1:0]    func_sel;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [1:0]    act_func;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic          busy;
  logic          done;

  int n_checks = 0;
  int n_pass   = 0;

  act_sequencer #(
    .ADDR_WIDTH   (AW),
    .PIPE_LATENCY (L)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .start     (start),
    .base_addr (base_addr),
    .length    (length),
    .func_sel  (func_sel),
`ifdef ACT_SEQ_STALL_EN
    .stall     (stall),
`endif
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .act_func  (act_func),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .busy      (busy),
    .done      (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: an unstalled job of n elements is a fixed schedule over virtual
  // cycles 1..E; stalled cycles inside the read/drain window freeze that clock.
  task automatic run_job(input logic [AW-1:0] b, input logic [AW-1:0] n, input logic [1:0] f,
                         input int extra_start, input int st_lo, input int st_hi);
    int v;
    int vc;
    int k;
    int e_end;
    int nn;
    logic st;
    logic e_rd, e_wr, e_busy, e_done;
    logic [AW-1:0] e_ra, e_wa;
    nn    = int'(n);
    e_end = (nn == 0) ? 1 : nn + L + 1;
    @(negedge clock);
    base_addr = b;
    length    = n;
    func_sel  = f;
    start     = 1'b1;
    @(posedge clock);
    #1;
    base_addr = AW'($urandom);
    length    = AW'($urandom);
    func_sel  = 2'($urandom);
    v = 0;
    k = 0;
    while (v < e_end + 2) begin
      k++;
      if (k > 200) begin
        check("job_timeout", 32'(k), 32'(200));
        break;
      end
      st    = (k >= st_lo) && (k <= st_hi);
      start = (k == extra_start);
      stall = st;
      #1;
      vc = v + 1;
`ifdef ACT_SEQ_STALL_EN
      if (st && nn != 0 && vc <= nn + L) begin
        e_rd = 1'b0; e_wr = 1'b0; e_busy = 1'b1; e_done = 1'b0;
        e_ra = '0;   e_wa = '0;
      end else
`endif
      begin
        v      = vc;
        e_rd   = (vc >= 1) && (vc <= nn);
        e_wr   = (vc >= 1 + L) && (vc <= nn + L);
        e_done = (vc == e_end);
        e_busy = (vc <= e_end);
        e_ra   = AW'(int'(b) + vc - 1);
        e_wa   = AW'(int'(b) + vc - 1 - L);
      end
      check($sformatf("rd_en b=%0d n=%0d c=%0d", b, n, k), 32'(rd_en), 32'(e_rd));
      check($sformatf("wr_en b=%0d n=%0d c=%0d", b, n, k), 32'(wr_en), 32'(e_wr));
      check($sformatf("busy b=%0d n=%0d c=%0d", b, n, k), 32'(busy), 32'(e_busy));
      check($sformatf("done b=%0d n=%0d c=%0d", b, n, k), 32'(done), 32'(e_done));
      check($sformatf("act_func b=%0d n=%0d c=%0d", b, n, k), 32'(act_func), 32'(f));
      if (e_rd) check($sformatf("rd_addr b=%0d n=%0d c=%0d", b, n, k), 32'(rd_addr), 32'(e_ra));
      if (e_wr) check($sformatf("wr_addr b=%0d n=%0d c=%0d", b, n, k), 32'(wr_addr), 32'(e_wa));
      @(posedge clock);
      #1;
    end
    start = 1'b0;
    stall = 1'b0;
  endtask

  initial begin
    int n;
    int es;
    reset_n   = 1'b0;
    start     = 1'b0;
    stall     = 1'b0;
    base_addr = '0;
    length    = '0;
    func_sel  = '0;
    repeat (3) @(posedge clock);
    #1;
    check("reset rd_en", 32'(rd_en), 32'd0);
    check("reset wr_en", 32'(wr_en), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset act_func", 32'(act_func), 32'd0);
    check("reset rd_addr", 32'(rd_addr), 32'd0);
    check("reset wr_addr", 32'(wr_addr), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;

    run_job(6'd10, 6'd4, 2'd2, 0, 0, 0);   // basic
    run_job(6'd62, 6'd4, 2'd1, 0, 0, 0);   // address wrap
    run_job(6'd7, 6'd0, 2'd3, 0, 0, 0);    // zero length
    run_job(6'd20, 6'd5, 2'd1, 2, 0, 0);   // start while busy
    run_job(6'd5, 6'd3, 2'd2, 7, 0, 0);    // start in the done cycle
    run_job(6'd9, 6'd0, 2'd1, 1, 0, 0);    // start in zero-length done cycle
    run_job(6'd63, 6'd1, 2'd0, 0, 0, 0);   // single element at the top

    // Reset in the middle of a length-8 job.
    @(negedge clock);
    base_addr = 6'd30; length = 6'd8; func_sel = 2'd3; start = 1'b1;
    @(posedge clock); #1; start = 1'b0;
    @(posedge clock); #1;
    @(posedge clock); #1;
    reset_n = 1'b0;
    #1;
    check("abort rd_en", 32'(rd_en), 32'd0);
    check("abort wr_en", 32'(wr_en), 32'd0);
    check("abort busy", 32'(busy), 32'd0);
    check("abort done", 32'(done), 32'd0);
    check("abort act_func", 32'(act_func), 32'd0);
    check("abort rd_addr", 32'(rd_addr), 32'd0);
    check("abort wr_addr", 32'(wr_addr), 32'd0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clock); #1;
      check($sformatf("post_abort rd_en c=%0d", i), 32'(rd_en), 32'd0);
      check($sformatf("post_abort wr_en c=%0d", i), 32'(wr_en), 32'd0);
      check($sformatf("post_abort busy c=%0d", i), 32'(busy), 32'd0);
    end
    run_job(6'd40, 6'd6, 2'd1, 0, 0, 0);

    for (int j = 0; j < 12; j++) begin
      n  = int'($urandom_range(0, 12));
      es = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, (n == 0) ? 1 : n + L + 1)) : 0;
      run_job(AW'($urandom), AW'(n), 2'($urandom), es, 0, 0);
    end

`ifdef ACT_SEQ_STALL_EN
    run_job(6'd10, 6'd4, 2'd2, 0, 2, 3);
    for (int j = 0; j < 8; j++) begin
      int lo;
      n  = int'($urandom_range(1, 10));
      lo = int'($urandom_range(1, n + L + 2));
      run_job(AW'($urandom), AW'(n), 2'($urandom), 0, lo, lo + int'($urandom_range(0, 3)));
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
